// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Purpose  : Program-counter register with RUN/HALTED control and saturating
//            performance counters. It sits between the next-PC mux and
//            instruction fetch. All state updates on the falling clock edge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1          clock (state updates on negedge)
//   clr          in   1          synchronous active-high reset
//   next_pc      in   PC_WIDTH   PC selected by the next-PC mux
//   pc_inc       in   2          00 seq, 01 branch, 10 jump, 11 halt
//   stall        in   1          hold PC this cycle
//   resume       in   1          leave HALTED
//   bp_addr      in   PC_WIDTH   breakpoint address     (PC_BREAKPOINT_EN)
//   bp_valid     in   1          breakpoint enable      (PC_BREAKPOINT_EN)
//   current_pc   out  PC_WIDTH   registered PC
//   halted       out  1          high while HALTED
//   cycle_count  out  CNT_WIDTH  cycles spent in RUN (starts at 1)
//   instr_count  out  CNT_WIDTH  PC advances
//   branch_count out  CNT_WIDTH  advances with pc_inc=01
//   jump_count   out  CNT_WIDTH  advances with pc_inc=10
//   stall_count  out  CNT_WIDTH  stalled cycles
// Optional feature macro: PC_BREAKPOINT_EN
// ============================================================================
`default_nettype none

module pc_unit #(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  CNT_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [PC_WIDTH-1:0]  next_pc,
  input  logic [1:0]           pc_inc,
  input  logic                 stall,
  input  logic                 resume,
`ifdef PC_BREAKPOINT_EN
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic                 bp_valid,
`endif
  output logic [PC_WIDTH-1:0]  current_pc,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] jump_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [1:0]           c_PC_INC_BRANCH = 2'b01;
  localparam logic [1:0]           c_PC_INC_JUMP   = 2'b10;
  localparam logic [1:0]           c_PC_INC_STOP   = 2'b11;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE       = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Declaration initialisers give power-up values identical to reset values.
  state_t               r_state  = ST_RUN;
  logic                 r_halted = 1'b0;
  logic [PC_WIDTH-1:0]  r_pc     = RESET_PC;
  logic [CNT_WIDTH-1:0] r_cycle  = c_CNT_ONE;
  logic [CNT_WIDTH-1:0] r_instr  = '0;
  logic [CNT_WIDTH-1:0] r_branch = '0;
  logic [CNT_WIDTH-1:0] r_jump   = '0;
  logic [CNT_WIDTH-1:0] r_stall  = '0;

  logic w_bp_hit;

`ifdef PC_BREAKPOINT_EN
  assign w_bp_hit = bp_valid && (next_pc == bp_addr);
`else
  assign w_bp_hit = 1'b0;
`endif

  // Saturating increment: an all-ones counter stays put instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : (v + c_CNT_ONE);
  endfunction

  always_ff @(negedge clk) begin
    if (clr) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
      r_pc     <= RESET_PC;
      r_cycle  <= c_CNT_ONE;
      r_instr  <= '0;
      r_branch <= '0;
      r_jump   <= '0;
      r_stall  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (pc_inc == c_PC_INC_STOP) begin
            // Halt outranks stall; PC and counters hold.
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (stall) begin
            r_cycle <= f_sat_inc(r_cycle);
            r_stall <= f_sat_inc(r_stall);
          end else begin
            r_pc    <= next_pc;
            r_cycle <= f_sat_inc(r_cycle);
            r_instr <= f_sat_inc(r_instr);
            if (pc_inc == c_PC_INC_BRANCH) r_branch <= f_sat_inc(r_branch);
            if (pc_inc == c_PC_INC_JUMP)   r_jump   <= f_sat_inc(r_jump);
            // Breakpoint: the matching instruction is loaded, then we stop.
            if (w_bp_hit) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          // Resume ignores pc_inc and the breakpoint so the core can step off.
          if (resume) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_pc     <= next_pc;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign current_pc   = r_pc;
  assign halted       = r_halted;
  assign cycle_count  = r_cycle;
  assign instr_count  = r_instr;
  assign branch_count = r_branch;
  assign jump_count   = r_jump;
  assign stall_count  = r_stall;

endmodule

`default_nettype wire
